// File: rtl/pingpong_dma_pkg.sv
// Shared types and constants for the ping-pong buffer DMA responder.
package pingpong_dma_pkg;

    localparam int BUF_ADDR_W = 9;
    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        FETCH,
        BEAT,
        STORE,
        DONE
    } state_e;

    typedef enum logic {
        OP_WRITE,
        OP_READ
    } op_e;

endpackage

// File: rtl/pingpong_dma_responder_sync_edge.sv
// sync_edge: multi-stage synchronizer for an asynchronous level plus a one-cycle rising-edge pulse.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic n_reset,
    input  logic async_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q[0] <= async_i;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rise_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/pingpong_dma_responder.sv
// pingpong_dma_responder: moves one ping-pong buffer half to/from system bus memory per JTAG DMA command.
// Bus error abort and the dma_error flag are built only when PINGPONG_DMA_ERROR_EN is defined.
module pingpong_dma_responder
    import pingpong_dma_pkg::*;
#(
    parameter int NB_WORDS    = 512,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        n_reset,
    input  logic [31:0] cmd_address,
    input  logic        cmd_write_req,
    input  logic        cmd_read_req,
    input  logic [3:0]  cmd_byte_enable,
    output logic        switch_ready,
    output logic [8:0]  buf_address,
    output logic        buf_write_enable,
    output logic [31:0] buf_data_out,
    input  logic [31:0] buf_data_in,
    output logic        bus_request,
    input  logic        bus_grant,
    output logic [31:0] bus_address,
    output logic        bus_write,
    output logic [3:0]  bus_byte_enable,
    output logic [31:0] bus_write_data,
    input  logic [31:0] bus_read_data,
    input  logic        bus_ack,
`ifdef PINGPONG_DMA_ERROR_EN
    input  logic        bus_error,
    output logic        dma_error,
`endif
    output logic [2:0]  dbg_state
);

    localparam logic [BUF_ADDR_W-1:0] LAST_IDX = BUF_ADDR_W'(NB_WORDS - 1);

    state_e                  state_q, state_d;
    op_e                     op_q, op_d;
    logic                    pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    logic                    ready_q, ready_d;
    logic [BUF_ADDR_W-1:0]   idx_q, idx_d;
    logic [31:0]             addr_q, addr_d, rdata_q, rdata_d;
    logic [3:0]              be_q, be_d;
    logic                    rise_wr, rise_rd, clr_wr, clr_rd, advance, beat_err;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_wr (
        .clock(clock), .n_reset(n_reset), .async_i(cmd_write_req), .rise_o(rise_wr)
    );
    sync_edge #(.STAGES(SYNC_STAGES)) u_sync_rd (
        .clock(clock), .n_reset(n_reset), .async_i(cmd_read_req), .rise_o(rise_rd)
    );

`ifdef PINGPONG_DMA_ERROR_EN
    logic err_q, err_d;
    assign beat_err  = bus_error;
    assign dma_error = err_q;
`else
    assign beat_err = 1'b0;
`endif

    // Bus handshake: bus_request is held from GRANT until DONE; a beat is open for every
    // cycle spent in BEAT and completes on the clock edge where bus_ack is sampled high.
    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        idx_d            = idx_q;
        addr_d           = addr_q;
        be_d             = be_q;
        rdata_d          = rdata_q;
`ifdef PINGPONG_DMA_ERROR_EN
        err_d            = err_q;
`endif
        clr_wr           = 1'b0;
        clr_rd           = 1'b0;
        advance          = 1'b0;
        bus_request      = 1'b0;
        bus_address      = '0;
        bus_write        = 1'b0;
        bus_byte_enable  = '0;
        bus_write_data   = '0;
        buf_address      = '0;
        buf_write_enable = 1'b0;
        buf_data_out     = '0;

        case (state_q)
            IDLE: begin
                if (pend_wr_q || pend_rd_q) begin
                    op_d   = pend_wr_q ? OP_WRITE : OP_READ;
                    clr_wr = pend_wr_q;
                    clr_rd = !pend_wr_q;
                    addr_d = cmd_address & ~32'h3;
                    be_d   = cmd_byte_enable;
                    idx_d  = '0;
`ifdef PINGPONG_DMA_ERROR_EN
                    err_d  = 1'b0;
`endif
                    state_d = GRANT;
                end
            end
            GRANT: begin
                bus_request = 1'b1;
                if (bus_grant) state_d = (op_q == OP_WRITE) ? FETCH : BEAT;
            end
            FETCH: begin
                bus_request = 1'b1;
                buf_address = idx_q;
                state_d     = BEAT;
            end
            BEAT: begin
                bus_request     = 1'b1;
                bus_address     = addr_q;
                bus_write       = (op_q == OP_WRITE);
                bus_byte_enable = (op_q == OP_WRITE) ? be_q : 4'hF;
                // Re-reading the same buffer word keeps write data stable until the ack.
                if (op_q == OP_WRITE) begin
                    buf_address    = idx_q;
                    bus_write_data = buf_data_in;
                end
                if (bus_ack) begin
                    if (beat_err) begin
`ifdef PINGPONG_DMA_ERROR_EN
                        err_d = 1'b1;
`endif
                        state_d = DONE;
                    end else if (op_q == OP_WRITE) begin
                        advance = 1'b1;
                    end else begin
                        rdata_d = bus_read_data;
                        state_d = STORE;
                    end
                end
            end
            STORE: begin
                bus_request      = 1'b1;
                buf_address      = idx_q;
                buf_write_enable = 1'b1;
                buf_data_out     = rdata_q;
                advance          = 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (advance) begin
            idx_d  = idx_q + 1'b1;
            addr_d = addr_q + 32'(WORD_BYTES);
            if (idx_q == LAST_IDX)      state_d = DONE;
            else if (op_q == OP_WRITE)  state_d = FETCH;
            else                        state_d = BEAT;
        end

        // Repeated edges while a flag is set merge into the one pending command.
        pend_wr_d = (pend_wr_q & ~clr_wr) | rise_wr;
        pend_rd_d = (pend_rd_q & ~clr_rd) | rise_rd;

        ready_d = ready_q;
        if (rise_wr || rise_rd)   ready_d = 1'b0;
        else if (state_q == DONE) ready_d = !(pend_wr_q || pend_rd_q);
    end

    always_ff @(posedge clock) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            op_q      <= OP_WRITE;
            pend_wr_q <= 1'b0;
            pend_rd_q <= 1'b0;
            ready_q   <= 1'b1;
            idx_q     <= '0;
            addr_q    <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pend_wr_q <= pend_wr_d;
            pend_rd_q <= pend_rd_d;
            ready_q   <= ready_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
        end
    end

`ifdef PINGPONG_DMA_ERROR_EN
    always_ff @(posedge clock) begin
        if (!n_reset) err_q <= 1'b0;
        else          err_q <= err_d;
    end
`endif

    assign switch_ready = ready_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_pingpong_dma_responder.sv
// Self-checking bench for pingpong_dma_responder: directed table, corner sequences and random commands.
module tb_pingpong_dma_responder;
    import pingpong_dma_pkg::*;

    localparam int NB = 4;

    logic        clock = 1'b0;
    logic        n_reset;
    logic [31:0] cmd_address;
    logic        cmd_write_req, cmd_read_req;
    logic [3:0]  cmd_byte_enable;
    logic        switch_ready;
    logic [8:0]  buf_address;
    logic        buf_write_enable;
    logic [31:0] buf_data_out, buf_data_in;
    logic        bus_request, bus_grant;
    logic [31:0] bus_address;
    logic        bus_write;
    logic [3:0]  bus_byte_enable;
    logic [31:0] bus_write_data, bus_read_data;
    logic        bus_ack;
    logic [2:0]  dbg_state;
`ifdef PINGPONG_DMA_ERROR_EN
    logic        bus_error, dma_error;
    int          err_target = -1;
`endif

    pingpong_dma_responder #(.NB_WORDS(NB), .SYNC_STAGES(2)) dut (
        .clock(clock), .n_reset(n_reset),
        .cmd_address(cmd_address), .cmd_write_req(cmd_write_req), .cmd_read_req(cmd_read_req),
        .cmd_byte_enable(cmd_byte_enable), .switch_ready(switch_ready),
        .buf_address(buf_address), .buf_write_enable(buf_write_enable),
        .buf_data_out(buf_data_out), .buf_data_in(buf_data_in),
        .bus_request(bus_request), .bus_grant(bus_grant), .bus_address(bus_address),
        .bus_write(bus_write), .bus_byte_enable(bus_byte_enable), .bus_write_data(bus_write_data),
        .bus_read_data(bus_read_data), .bus_ack(bus_ack),
`ifdef PINGPONG_DMA_ERROR_EN
        .bus_error(bus_error), .dma_error(dma_error),
`endif
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // scoreboard state
    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] data;
    } beat_t;

    beat_t       exp_q[$];
    logic [31:0] rd_src[$];
    logic [31:0] buf_model [0:511];
    logic [31:0] buf_mem   [0:511];
    logic        init_buf;
    int          n_vec = 0, n_fail = 0;
    int          beats_seen = 0, we_count = 0;
    int          ack_wait = 0, grant_delay = 0, cnt = 0, gcnt = 0;
    beat_t       got_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // buffer model: registered read, write strobe from DUT
    always @(posedge clock) begin
        if (init_buf) begin
            for (int i = 0; i < 512; i++) buf_mem[i] <= 32'hA0 + 32'(i);
        end else if (buf_write_enable) begin
            buf_mem[buf_address] <= buf_data_out;
            we_count <= we_count + 1;
        end
        buf_data_in <= buf_mem[buf_address];
    end

    // bus slave: grant after grant_delay, ack each beat after ack_wait cycles, check beats
    always @(negedge clock) begin
        bus_ack = 1'b0;
`ifdef PINGPONG_DMA_ERROR_EN
        bus_error = 1'b0;
`endif
        if (!n_reset) begin
            bus_grant = 1'b0; bus_read_data = '0; gcnt = 0; cnt = 0;
        end else begin
            if (bus_request) begin
                if (gcnt >= grant_delay) bus_grant = 1'b1;
                else gcnt++;
            end else begin
                bus_grant = 1'b0; gcnt = 0;
            end
            if (dbg_state == BEAT) begin
                if (cnt >= ack_wait) begin
                    cnt = 0;
                    bus_ack = 1'b1;
                    if (!bus_write && rd_src.size() > 0) bus_read_data = rd_src.pop_front();
`ifdef PINGPONG_DMA_ERROR_EN
                    bus_error = (beats_seen == err_target);
`endif
                    beats_seen++;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_beat: got addr %h wr %b, required no beat", bus_address, bus_write);
                    end else begin
                        got_e = exp_q.pop_front();
                        if (bus_address !== got_e.addr || bus_write !== got_e.wr ||
                            bus_byte_enable !== got_e.be || (got_e.wr && bus_write_data !== got_e.data)) begin
                            n_fail++;
                            $display("FAIL beat: got addr %h wr %b be %h data %h, required addr %h wr %b be %h data %h",
                                     bus_address, bus_write, bus_byte_enable, bus_write_data,
                                     got_e.addr, got_e.wr, got_e.be, got_e.data);
                        end
                    end
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // reference model: a command is NB consecutive words from the word-aligned start address
    task automatic model_cmd(input bit wr, input bit rd, input logic [31:0] addr,
                             input logic [3:0] be, input logic [31:0] seed);
        logic [31:0] base, v;
        beat_t b;
        base = addr & 32'hFFFF_FFFC;
        if (wr) begin
            for (int i = 0; i < NB; i++) begin
                b = '{addr: base + 32'(4 * i), wr: 1'b1, be: be, data: buf_model[i]};
                exp_q.push_back(b);
            end
        end
        if (rd) begin
            for (int i = 0; i < NB; i++) begin
                v = (seed != 0) ? seed * 32'(i + 1) : $urandom();
                rd_src.push_back(v);
                b = '{addr: base + 32'(4 * i), wr: 1'b0, be: 4'hF, data: 32'h0};
                exp_q.push_back(b);
                buf_model[i] = v;
            end
        end
    endtask

    // driver: raise request edge(s), wait for busy then idle, check totals
    task automatic run_cmd(input bit wr, input bit rd, input logic [31:0] addr, input logic [3:0] be,
                           input int exp_beats, input int exp_we);
        int b0, w0, k;
        b0 = beats_seen;
        w0 = we_count;
        @(negedge clock);
        cmd_address = addr; cmd_byte_enable = be;
        cmd_write_req = wr; cmd_read_req = rd;
        repeat (3) @(negedge clock);
        cmd_write_req = 1'b0; cmd_read_req = 1'b0;
        k = 0;
        while (switch_ready && k < 20) begin @(negedge clock); k++; end
        chk("switch_ready_drop", {31'b0, switch_ready}, 32'd0);
        k = 0;
        while (!switch_ready && k < 3000) begin @(negedge clock); k++; end
        chk("switch_ready_return", {31'b0, switch_ready}, 32'd1);
        chk("beat_count", beats_seen - b0, exp_beats);
        chk("buf_we_pulses", we_count - w0, exp_we);
        chk("exp_q_drained", exp_q.size(), 32'd0);
        if (rd) begin
            for (int i = 0; i < NB; i++) chk("buf_word", buf_mem[i], buf_model[i]);
        end
    endtask

    typedef struct {
        bit          do_wr;
        bit          do_rd;
        logic [31:0] addr;
        logic [3:0]  be;
        int          wait_c;
        logic [31:0] rd_seed;
        int          exp_beats;
        int          exp_we;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int b0, k, kind;
        bit rw, rr;

        tbl[0] = '{1'b1, 1'b0, 32'h0000_1003, 4'hA, 2, 32'h0,  4, 0};
        tbl[1] = '{1'b0, 1'b1, 32'h0000_2000, 4'h0, 1, 32'h11, 4, 4};
        tbl[2] = '{1'b1, 1'b1, 32'h0000_3000, 4'h5, 0, 32'h0,  8, 4};
        tbl[3] = '{1'b1, 1'b0, 32'hFFFF_FFFE, 4'h3, 1, 32'h0,  4, 0};
        tbl[4] = '{1'b0, 1'b1, 32'hFFFF_FFF8, 4'hF, 3, 32'h0,  4, 4};

        n_reset = 1'b0; init_buf = 1'b1;
        cmd_address = '0; cmd_write_req = 1'b0; cmd_read_req = 1'b0; cmd_byte_enable = '0;
        for (int i = 0; i < 512; i++) buf_model[i] = 32'hA0 + 32'(i);
        repeat (3) @(negedge clock);
        chk("reset_switch_ready", {31'b0, switch_ready}, 32'd1);
        chk("reset_bus_request", {31'b0, bus_request}, 32'd0);
        chk("reset_buf_we", {31'b0, buf_write_enable}, 32'd0);
        chk("reset_bus_address", bus_address, 32'd0);
        chk("reset_buf_address", {23'b0, buf_address}, 32'd0);
        init_buf = 1'b0;
        n_reset = 1'b1;
        @(negedge clock);

        for (int t = 0; t < 5; t++) begin
            ack_wait = tbl[t].wait_c;
            model_cmd(tbl[t].do_wr, tbl[t].do_rd, tbl[t].addr, tbl[t].be, tbl[t].rd_seed);
            run_cmd(tbl[t].do_wr, tbl[t].do_rd, tbl[t].addr, tbl[t].be, tbl[t].exp_beats, tbl[t].exp_we);
        end

        // reset during the second beat abandons the transfer
        ack_wait = 2;
        model_cmd(1'b1, 1'b0, 32'h0000_4000, 4'hF, 32'h0);
        b0 = beats_seen;
        @(negedge clock);
        cmd_address = 32'h0000_4000; cmd_byte_enable = 4'hF; cmd_write_req = 1'b1;
        repeat (3) @(negedge clock);
        cmd_write_req = 1'b0;
        k = 0;
        while (!(beats_seen == b0 + 1 && dbg_state == BEAT) && k < 500) begin @(negedge clock); k++; end
        chk("mid_reset_reached_beat2", beats_seen - b0, 32'd1);
        n_reset = 1'b0;
        @(posedge clock);
        #1;
        chk("mid_reset_bus_request", {31'b0, bus_request}, 32'd0);
        chk("mid_reset_switch_ready", {31'b0, switch_ready}, 32'd1);
        @(negedge clock);
        n_reset = 1'b1;
        exp_q.delete();
        ack_wait = 1;
        model_cmd(1'b1, 1'b0, 32'h0000_5000, 4'hC, 32'h0);
        run_cmd(1'b1, 1'b0, 32'h0000_5000, 4'hC, 4, 0);

`ifdef PINGPONG_DMA_ERROR_EN
        // bus error on the second ack ends the write after two beats
        ack_wait = 1;
        err_target = beats_seen + 1;
        model_cmd(1'b1, 1'b0, 32'h0000_6000, 4'hF, 32'h0);
        while (exp_q.size() > 2) exp_q.pop_back();
        run_cmd(1'b1, 1'b0, 32'h0000_6000, 4'hF, 2, 0);
        chk("dma_error_set", {31'b0, dma_error}, 32'd1);
        err_target = -1;
        model_cmd(1'b1, 1'b0, 32'h0000_7000, 4'hF, 32'h0);
        run_cmd(1'b1, 1'b0, 32'h0000_7000, 4'hF, 4, 0);
        chk("dma_error_cleared", {31'b0, dma_error}, 32'd0);
`endif

        // random commands, random bus latencies
        for (int r = 0; r < 10; r++) begin
            logic [31:0] a;
            logic [3:0]  be;
            kind = $urandom_range(1, 3);
            rw = kind[0];
            rr = kind[1];
            a  = $urandom();
            be = 4'($urandom_range(0, 15));
            ack_wait    = $urandom_range(0, 3);
            grant_delay = $urandom_range(0, 3);
            model_cmd(rw, rr, a, be, 32'h0);
            run_cmd(rw, rr, a, be, NB * (int'(rw) + int'(rr)), NB * int'(rr));
        end

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
